instr_issue_unit: RTL and testbench
===================================

// Module: instr_issue_unit
// PURPOSE
//  Fetch/issue front end that feeds 32-bit IR words to the GPR execute stage.
//  Reads sequential words from a synchronous program memory (1-cycle read latency).
//  Buffers them in a 2-entry queue and presents them over a valid/ready handshake.
//  Stops at a HALT opcode. IR fields: oper[31:27] rdst[26:22] rsrc1[21:17] mode[16] rsrc2[15:11] imm[15:0].
// PARAMETERS
//  AW        8      program memory address width; PC wraps modulo 2**AW
//  RESET_PC  0      first fetch address after start
//  CNT_W     16     width of issued-instruction counter
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    asynchronous, active-low reset
//  start       in   1    pulse: begin fetching at RESET_PC (ignored while RUN/DRAIN)
//  stop        in   1    abort: flush queue, drop in-flight read, return to IDLE
//  imem_rd     out  1    program memory read strobe
//  imem_addr   out  AW   read address (= pc)
//  imem_rdata  in   32   read data, valid the cycle after imem_rd
//  ir_out      out  32   instruction at queue head
//  ir_valid    out  1    ir_out holds a valid instruction
//  ir_ready    in   1    execute stage accepts ir_out this cycle
//  pc_out      out  AW   address of the instruction on ir_out
//  halted      out  1    HALT reached and queue drained
//  issued_cnt  out  CNT_W  instructions accepted by the execute stage, saturating
// BEHAVIOUR
//  Reset values: state IDLE; pc = RESET_PC; imem_rd = 0; imem_addr = RESET_PC; ir_out = 0.
//   Also ir_valid = 0, pc_out = 0, halted = 0, issued_cnt = 0; queue empty; no read in flight.
//  States:
//   IDLE  : start -> RUN; pc <= RESET_PC; issued_cnt <= 0.
//   RUN   : issue reads; a returning word with oper == OP_HALT -> DRAIN.
//   DRAIN : no reads; queue empties -> HALT.
//   HALT  : halted = 1; start -> RUN; halted clears; pc <= RESET_PC; cnt <= 0.
//  Reads and flow control:
//   - In RUN, imem_rd = 1 (combinational) when occupancy + inflight < 2.
//   - On each read, pc <= pc + 1, wrapping 2**AW-1 -> 0.
//   - The return word is pushed the cycle after imem_rd, tagged with its address.
//   - The HALT word is never pushed to the queue. A read already in flight when HALT returns is discarded.
//  Output handshake:
//   - ir_valid = queue not empty.
//   - Pop on ir_valid && ir_ready.
//   - ir_out and pc_out stay stable while ir_valid && !ir_ready.
//   - Push and pop in the same cycle are both allowed; occupancy stays unchanged.
//  Latency and throughput:
//   - start high in cycle 0 -> imem_rd in cycle 1 with addr RESET_PC -> ir_valid in cycle 3.
//   - With ir_ready held 1, sustained throughput is 1 instruction/cycle.
//  Boundary cases:
//   - Queue full: no new read is issued.
//   - ir_ready low for N cycles: no word is lost or duplicated.
//   - stop in any state: next cycle IDLE, queue empty, ir_valid = 0, in-flight data dropped.
//   - stop has priority over start in the same cycle.
//   - HALT as the very first word: DRAIN then HALT with zero issued instructions.
//   - issued_cnt saturates at 2**CNT_W-1.
//   - rst_n asserted mid-operation: all state returns to reset values immediately (async).
// STRUCTURE
//  Shared package ir_pkg:
//   - Field positions/widths.
//   - Opcodes: OP_MOVSGPR=5'd0, OP_MOV=5'd1, OP_ADD=5'd2, OP_SUB=5'd3, OP_MUL=5'd4, OP_HALT=5'd31.
//   - State enum issue_state_t {IDLE, RUN, DRAIN, HALT}.
//  Sub-module: ir_fifo2 — synchronous 2-entry queue of {AW addr, 32 data}.
//   - Outputs full/empty/count.
//  The top level holds the FSM, pc, in-flight flag, HALT detection, issued counter.
// TESTING
//  1. Memory 0..3 = ADD,SUB,MUL,HALT; ready=1; pulse start.
//     -> ir_valid cycle 3; three words issued with pc_out 0,1,2; HALT not issued.
//     -> halted=1; issued_cnt=3.
//  2. Same program with ir_ready held 0 for 5 cycles, then 1.
//     -> at most 2 reads outstanding+queued; ir_out holds 0x10000000-style word stable.
//     -> all words delivered in order.
//  3. AW=3, 8 non-HALT words; run 12 accepts.
//     -> pc_out sequence 0..7,0,1,2,3 (wrap); issued_cnt=12.
//  4. stop asserted while queue full and read in flight.
//     -> next cycle IDLE, ir_valid=0; a later start refetches from RESET_PC with no stale word.
//  5. start and stop high together in IDLE -> remains IDLE, imem_rd stays 0.
//  6. rst_n low for 1 cycle mid-RUN -> all outputs at reset values; start resumes from RESET_PC.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared IR field layout, opcodes and issue-unit state encoding.
package ir_pkg;

  localparam int unsigned IR_W      = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned OPER_LSB  = 27;
  localparam int unsigned OPER_W    = 5;
  localparam int unsigned RDST_LSB  = 22;
  localparam int unsigned RSRC1_LSB = 17;
  localparam int unsigned MODE_BIT  = 16;
  localparam int unsigned RSRC2_LSB = 11;
  localparam int unsigned IMM_W     = 16;

  typedef enum logic [OPER_W-1:0] {
    OP_MOVSGPR = 5'd0,
    OP_MOV     = 5'd1,
    OP_ADD     = 5'd2,
    OP_SUB     = 5'd3,
    OP_MUL     = 5'd4,
    OP_HALT    = 5'd31
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } issue_state_t;

  // Field extraction helpers
  function automatic logic [OPER_W-1:0] ir_oper(input logic [IR_W-1:0] ir);
    return ir[OPER_LSB +: OPER_W];
  endfunction

  function automatic logic [REG_W-1:0] ir_rdst(input logic [IR_W-1:0] ir);
    return ir[RDST_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] ir_rsrc1(input logic [IR_W-1:0] ir);
    return ir[RSRC1_LSB +: REG_W];
  endfunction

  function automatic logic ir_mode(input logic [IR_W-1:0] ir);
    return ir[MODE_BIT];
  endfunction

  function automatic logic [REG_W-1:0] ir_rsrc2(input logic [IR_W-1:0] ir);
    return ir[RSRC2_LSB +: REG_W];
  endfunction

  function automatic logic [IMM_W-1:0] ir_imm(input logic [IR_W-1:0] ir);
    return ir[IMM_W-1:0];
  endfunction

endpackage

// File: rtl/ir_fifo2.sv
// Two-entry shift queue; entry 0 is always the head.
module ir_fifo2 #(
  parameter int unsigned DW = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic [DW-1:0] e0;
  logic [DW-1:0] e1;
  logic [1:0]    cnt;
  logic          do_push;
  logic          do_pop;

  // Qualify requests against occupancy; a push into a full queue needs a same-cycle pop
  always_comb begin
    do_pop  = pop && (cnt != 2'd0);
    do_push = push && ((cnt != 2'd2) || do_pop);
  end

  // Storage and occupancy update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign dout  = e0;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/instr_issue_unit.sv
// Fetch/issue front end: sequential program-memory reads, 2-entry IR queue,
// valid/ready issue handshake, stops at HALT.
module instr_issue_unit
  import ir_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  output logic             imem_rd,
  output logic [AW-1:0]    imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir_out,
  output logic             ir_valid,
  input  logic             ir_ready,
  output logic [AW-1:0]    pc_out,
  output logic             halted,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam int unsigned      DW      = AW + IR_W;
  localparam logic [AW-1:0]    PC_RST  = AW'(RESET_PC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  issue_state_t     state;
  logic [AW-1:0]    pc;
  logic             inflight;
  logic [AW-1:0]    inflight_addr;
  logic [CNT_W-1:0] issued;
  logic             halted_q;

  logic             pop;
  logic             push;
  logic             rd;
  logic             ret_halt;
  logic [2:0]       credit;
  logic [DW-1:0]    fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_count;

  // Read issue and queue push decisions; a pop this cycle frees a slot for a new read
  always_comb begin
    pop      = !fifo_empty && ir_ready;
    ret_halt = inflight && (ir_oper(imem_rdata) == OP_HALT);
    credit   = 3'(fifo_count) + 3'(inflight);
    rd       = (state == RUN) && !stop && !ret_halt &&
               (credit < (3'd2 + 3'(pop)));
    push     = (state == RUN) && inflight && !ret_halt && !stop &&
               (!fifo_full || pop);
  end

  ir_fifo2 #(.DW(DW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (stop),
    .push  (push),
    .din   ({inflight_addr, imem_rdata}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FSM, pc, in-flight tracking and saturating issue counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= PC_RST;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      issued        <= '0;
      halted_q      <= 1'b0;
    end else begin
      inflight <= rd;
      if (rd) begin
        pc            <= pc + AW'(1);
        inflight_addr <= pc;
      end
      if (pop && (issued != CNT_MAX)) issued <= issued + CNT_W'(1);

      if (stop) begin
        state    <= IDLE;
        halted_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state  <= RUN;
              pc     <= PC_RST;
              issued <= '0;
            end
          end
          RUN: begin
            if (ret_halt) state <= DRAIN;
          end
          DRAIN: begin
            if (fifo_empty) begin
              state    <= HALT;
              halted_q <= 1'b1;
            end
          end
          HALT: begin
            if (start) begin
              state    <= RUN;
              halted_q <= 1'b0;
              pc       <= PC_RST;
              issued   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign imem_rd    = rd;
  assign imem_addr  = pc;
  assign ir_out     = fifo_dout[IR_W-1:0];
  assign pc_out     = fifo_dout[DW-1:IR_W];
  assign ir_valid   = !fifo_empty;
  assign halted     = halted_q;
  assign issued_cnt = issued;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Scoreboard bench for instr_issue_unit with a 1-cycle synchronous program memory.
module tb_instr_issue_unit;

  localparam int unsigned AW    = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct {
    logic [31:0]   ir;
    logic [AW-1:0] pc;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             imem_rd;
  logic [AW-1:0]    imem_addr;
  logic [31:0]      imem_rdata;
  logic [31:0]      ir_out;
  logic             ir_valid;
  logic             ir_ready;
  logic [AW-1:0]    pc_out;
  logic             halted;
  logic [CNT_W-1:0] issued_cnt;

  logic [31:0] mem [DEPTH];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          acc      = 0;
  int          rd_total = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] hold_ir;
  logic [AW-1:0] hold_pc;

  localparam logic [31:0] W_ADD  = {5'd2,  5'd1, 5'd2, 1'b0, 5'd3, 11'd0};
  localparam logic [31:0] W_SUB  = {5'd3,  5'd4, 5'd5, 1'b1, 16'h0123};
  localparam logic [31:0] W_MUL  = {5'd4,  5'd7, 5'd8, 1'b0, 5'd9, 11'h055};
  localparam logic [31:0] W_HALT = {5'd31, 27'h0};

  instr_issue_unit #(.AW(AW), .RESET_PC(0), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ir_out     (ir_out),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .pc_out     (pc_out),
    .halted     (halted),
    .issued_cnt (issued_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous program memory model
  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= mem[imem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard pop on accept, stability while stalled
  always @(negedge clk) begin
    if (imem_rd) rd_total++;
    if (rst_n && ir_valid) begin
      if (stall_prev) begin
        check("hold_ir", ir_out, hold_ir);
        check("hold_pc", pc_out, hold_pc);
      end
      if (ir_ready) begin
        exp_t e;
        acc++;
        stall_prev = 1'b0;
        check("sb_has_entry", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("ir_out", ir_out, e.ir);
          check("pc_out", pc_out, e.pc);
        end
      end else begin
        stall_prev = 1'b1;
        hold_ir    = ir_out;
        hold_pc    = pc_out;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic load_prog1();
    mem[0] = W_ADD;
    mem[1] = W_SUB;
    mem[2] = W_MUL;
    mem[3] = W_HALT;
    for (int i = 4; i < int'(DEPTH); i++) mem[i] = {5'd1, 27'(i * 11)};
  endtask

  // Expected issue stream: words from RESET_PC up to (not including) HALT
  task automatic expect_until_halt();
    for (int i = 0; i < int'(DEPTH); i++) begin
      exp_t e;
      if (mem[i][31:27] == 5'd31) break;
      e.ir = mem[i];
      e.pc = AW'(i);
      sb.push_back(e);
    end
  endtask

  task automatic wait_halted(input string tag, input int max);
    for (int i = 0; i < max && !halted; i++) tick(1);
    check(tag, halted, 1'b1);
  endtask

  task automatic wait_acc(input string tag, input int target, input int max);
    for (int i = 0; i < max && acc < target; i++) tick(1);
    check(tag, acc, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"},     imem_rd,    1'b0);
    check({tag, "_addr"},   imem_addr,  0);
    check({tag, "_ir"},     ir_out,     0);
    check({tag, "_valid"},  ir_valid,   1'b0);
    check({tag, "_pc"},     pc_out,     0);
    check({tag, "_halted"}, halted,     1'b0);
    check({tag, "_cnt"},    issued_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    ir_ready = 1'b0;
    load_prog1();
    tick(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick(2);

    // 1: ADD,SUB,MUL,HALT with ready held high; first-valid latency
    ir_ready = 1'b1;
    expect_until_halt();
    start_pulse();
    check("t1_rd_c1", imem_rd, 1'b1);
    check("t1_addr_c1", imem_addr, 0);
    tick(1);
    check("t1_valid_c2", ir_valid, 1'b0);
    tick(1);
    check("t1_valid_c3", ir_valid, 1'b1);
    wait_halted("t1_halted", 40);
    check("t1_cnt", issued_cnt, 3);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_rd_idle", imem_rd, 1'b0);

    // 2: same program, execute stage stalled after start
    ir_ready = 1'b0;
    expect_until_halt();
    base = rd_total;
    start_pulse();
    check("t2_halted_clr", halted, 1'b0);
    tick(6);
    check("t2_reads", rd_total - base, 2);
    check("t2_head", ir_out, W_ADD);
    check("t2_valid", ir_valid, 1'b1);
    ir_ready = 1'b1;
    wait_halted("t2_halted", 40);
    check("t2_cnt", issued_cnt, 3);
    check("t2_sb_empty", sb.size(), 0);

    // 3: eight non-HALT words, pc wrap and counter saturation
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = {5'(i % 5), 27'(i * 37 + 5)};
    for (int i = 0; i < 20; i++) begin
      exp_t e;
      e.ir = mem[i % int'(DEPTH)];
      e.pc = AW'(i);
      sb.push_back(e);
    end
    base = acc;
    ir_ready = 1'b1;
    start_pulse();
    wait_acc("t3_acc12", base + 12, 100);
    ir_ready = 1'b0;
    check("t3_cnt12", issued_cnt, 12);
    tick(3);
    check("t3_full_valid", ir_valid, 1'b1);
    check("t3_full_no_rd", imem_rd, 1'b0);
    ir_ready = 1'b1;
    wait_acc("t3_acc20", base + 20, 100);
    ir_ready = 1'b0;
    check("t3_cnt_sat", issued_cnt, 15);
    check("t3_sb_empty", sb.size(), 0);

    // 4a: stop while the queue is full and stalled
    tick(3);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t4_valid", ir_valid, 1'b0);
    check("t4_rd", imem_rd, 1'b0);
    check("t4_halted", halted, 1'b0);
    tick(2);
    check("t4_idle_rd", imem_rd, 1'b0);
    load_prog1();
    ir_ready = 1'b1;
    expect_until_halt();
    start_pulse();
    wait_halted("t4_refetch_halted", 40);
    check("t4_refetch_cnt", issued_cnt, 3);
    check("t4_sb_empty", sb.size(), 0);

    // 4b: stop with a read in flight during streaming
    expect_until_halt();
    start_pulse();
    tick(2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    sb.delete();
    check("t4b_valid", ir_valid, 1'b0);
    check("t4b_rd", imem_rd, 1'b0);
    tick(3);
    check("t4b_valid_late", ir_valid, 1'b0);
    check("t4b_cnt", issued_cnt, 1);

    // 5: start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    check("t5_rd", imem_rd, 1'b0);
    tick(3);
    check("t5_rd_late", imem_rd, 1'b0);
    check("t5_valid", ir_valid, 1'b0);

    // 6: asynchronous reset mid-run, then restart
    expect_until_halt();
    ir_ready = 1'b1;
    start_pulse();
    tick(2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    sb.delete();
    tick(1);
    rst_n = 1'b1;
    tick(1);
    expect_until_halt();
    start_pulse();
    check("t6_addr_restart", imem_addr, 0);
    wait_halted("t6_halted", 40);
    check("t6_cnt", issued_cnt, 3);
    check("t6_sb_empty", sb.size(), 0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
